// File: rtl/mem_dump_reader_if.sv
// ---------------------------------------------------------------------------
// mem_dump_reader_if
// Bundles the control, memory read port and byte stream of mem_dump_reader.
//
//   Control : start, base_addr, word_count (to reader); busy, done (from reader)
//   Memory  : mem_rd_en, mem_addr (from reader); mem_rdata (to reader)
//   Stream  : tx_data, tx_valid (from reader); tx_ready (to reader)
//
// Modports:
//   master - the dump reader itself
//   slave  - the surrounding system (requester, memory and byte sink)
// ---------------------------------------------------------------------------
interface mem_dump_reader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        input  start, base_addr, word_count, mem_rdata, tx_ready,
        output busy, done, mem_rd_en, mem_addr, tx_data, tx_valid
    );

    modport slave (
        output start, base_addr, word_count, mem_rdata, tx_ready,
        input  busy, done, mem_rd_en, mem_addr, tx_data, tx_valid
    );
endinterface

// File: rtl/mem_dump_reader.sv
// ---------------------------------------------------------------------------
// mem_dump_reader
// Reads word_count consecutive 32-bit words starting at base_addr from a
// synchronous-read memory and streams them MSB-first as bytes.
//
// Ports:
//   clk         - system clock, rising edge
//   reset       - asynchronous, active-low reset
//   dump_if     - mem_dump_reader_if.master (control, memory port, byte stream)
//   o_dbg_state - current FSM state encoding, for observation only
//
// Optional feature: define DUMP_CHECKSUM_EN to append one byte holding the
// modulo-256 sum of all data bytes of the dump after the last data byte.
//
// Stream handshake: a byte transfers at a rising edge where tx_valid and
// tx_ready are both high. tx_valid/tx_data depend only on registered state,
// so once tx_valid rises it stays high with tx_data stable until the
// transfer; tx_ready never feeds tx_valid combinationally.
// ---------------------------------------------------------------------------
module mem_dump_reader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    mem_dump_reader_if.master dump_if,
    output logic [2:0]        o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_WAIT   = 3'd2,
        S_SEND   = 3'd3,
`ifdef DUMP_CHECKSUM_EN
        S_CKSUM  = 3'd4,
`endif
        S_FINISH = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_index;
    logic [1:0]        r_byte;
    logic [31:0]       r_shift;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]        r_cksum;
`endif

    logic              w_tx_valid;
    logic              w_tx_fire;
    logic              w_last_byte;
    logic [ADDR_W:0]   w_index_inc;
    logic [ADDR_W-1:0] w_rd_addr;

`ifdef DUMP_CHECKSUM_EN
    assign w_tx_valid  = (r_state == S_SEND) || (r_state == S_CKSUM);
`else
    assign w_tx_valid  = (r_state == S_SEND);
`endif
    assign w_tx_fire   = w_tx_valid && dump_if.tx_ready;
    assign w_last_byte = (r_byte == 2'd3);
    assign w_index_inc = r_index + 1'b1;
    // Truncating the index makes the address wrap from the top word to 0.
    assign w_rd_addr   = r_base + r_index[ADDR_W-1:0];
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next            = r_state;
        dump_if.busy      = 1'b0;
        dump_if.done      = 1'b0;
        dump_if.mem_rd_en = 1'b0;
        dump_if.mem_addr  = r_addr_hold;
        dump_if.tx_data   = 8'h00;
        dump_if.tx_valid  = w_tx_valid;
        case (r_state)
            S_IDLE: begin
                if (dump_if.start) begin
                    w_next = (dump_if.word_count == '0) ? S_FINISH : S_READ;
                end
            end
            S_READ: begin
                dump_if.busy      = 1'b1;
                dump_if.mem_rd_en = 1'b1;
                dump_if.mem_addr  = w_rd_addr;
                w_next            = S_WAIT;
            end
            S_WAIT: begin
                dump_if.busy = 1'b1;
                w_next       = S_SEND;
            end
            S_SEND: begin
                dump_if.busy    = 1'b1;
                dump_if.tx_data = r_shift[31:24];
                if (w_tx_fire && w_last_byte) begin
                    if (w_index_inc == r_count) begin
`ifdef DUMP_CHECKSUM_EN
                        w_next = S_CKSUM;
`else
                        w_next = S_FINISH;
`endif
                    end else begin
                        w_next = S_READ;
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            S_CKSUM: begin
                dump_if.busy    = 1'b1;
                dump_if.tx_data = r_cksum;
                if (w_tx_fire) begin
                    w_next = S_FINISH;
                end
            end
`endif
            S_FINISH: begin
                dump_if.done = 1'b1;
                w_next       = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_base      <= '0;
            r_addr_hold <= '0;
            r_count     <= '0;
            r_index     <= '0;
            r_byte      <= '0;
            r_shift     <= '0;
`ifdef DUMP_CHECKSUM_EN
            r_cksum     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (dump_if.start) begin
                        r_base  <= dump_if.base_addr;
                        r_count <= dump_if.word_count;
                        r_index <= '0;
                        r_byte  <= '0;
`ifdef DUMP_CHECKSUM_EN
                        r_cksum <= '0;
`endif
                    end
                end
                S_READ: begin
                    // Keeps mem_addr at the last read address outside READ.
                    r_addr_hold <= w_rd_addr;
                end
                S_WAIT: begin
                    r_shift <= dump_if.mem_rdata;
                end
                S_SEND: begin
                    if (w_tx_fire) begin
                        r_shift <= {r_shift[23:0], 8'h00};
                        // Two-bit counter wraps back to 0 after the 4th byte.
                        r_byte  <= r_byte + 2'd1;
`ifdef DUMP_CHECKSUM_EN
                        r_cksum <= r_cksum + r_shift[31:24];
`endif
                        if (w_last_byte) begin
                            r_index <= w_index_inc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_reader.sv
module tb_mem_dump_reader;
  localparam int ADDR_W = 8;
`ifdef DUMP_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  // clock / reset
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  mem_dump_reader_if #(.ADDR_W(ADDR_W)) dif ();

  mem_dump_reader #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .dump_if     (dif),
    .o_dbg_state (dbg_state)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // memory model: synchronous read, data valid the cycle after mem_rd_en
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (dif.mem_rd_en) dif.mem_rdata <= mem[dif.mem_addr];
  end

  // cycle counter and monitors (sampled on the falling edge)
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] rd_q[$];
  int   done_cnt = 0;
  int   done_cyc = -1;
  logic busy_at_done = 1'b0;
  logic valid_seen = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      if (dif.tx_valid && dif.tx_ready) got_q.push_back(dif.tx_data);
      if (dif.tx_valid) valid_seen = 1'b1;
      if (dif.mem_rd_en) rd_q.push_back(dif.mem_addr);
      if (dif.done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = dif.busy;
      end
    end
  end

  // driver tasks
  task automatic clear_logs();
    exp_q.delete();
    got_q.delete();
    rd_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    valid_seen = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  // called at posedge+1; returns the cycle index of the READ cycle
  task automatic pulse_start(input logic [7:0] b, input logic [8:0] c, output int e1);
    dif.start = 1'b1;
    dif.base_addr = b;
    dif.word_count = c;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    dif.base_addr = 8'hA5;
    dif.word_count = 9'd7;
    e1 = cyc;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
    #1;
    ok = (done_cnt != d0);
  endtask

  // scenarios
  task automatic test_reset();
    #1;
    tests_run++;
    if ({dif.busy, dif.done, dif.mem_rd_en, dif.tx_valid} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ctrl got %b want 0000", {dif.busy, dif.done, dif.mem_rd_en, dif.tx_valid});
    end
    tests_run++;
    if (dif.mem_addr !== 8'h00 || dif.tx_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_data got addr=%h data=%h want 00/00", dif.mem_addr, dif.tx_data);
    end
    tests_run++;
    if (dbg_state !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_state got %0d want 0", dbg_state);
    end
  endtask

  task automatic test_basic();
    int e1;
    bit ok;
    clear_logs();
    push_word(32'd12);
    push_word(32'd5);
    push_word(32'hFFFF_FFF8);
    if (CK != 0) exp_q.push_back(8'h06);
    dif.tx_ready = 1'b1;
    pulse_start(8'd250, 9'd3, e1);
    @(negedge clk);
    tests_run++;
    if (dif.mem_rd_en !== 1'b1 || dif.mem_addr !== 8'd250 || dif.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_read got rd=%b addr=%0d busy=%b want 1/250/1", dif.mem_rd_en, dif.mem_addr, dif.busy);
    end
    @(negedge clk);
    tests_run++;
    if (dif.tx_valid !== 1'b0 || dif.mem_rd_en !== 1'b0 || dif.mem_addr !== 8'd250) begin
      tests_failed++;
      $display("FAIL basic_wait got valid=%b rd=%b addr=%0d want 0/0/250", dif.tx_valid, dif.mem_rd_en, dif.mem_addr);
    end
    @(negedge clk);
    tests_run++;
    if (dif.tx_valid !== 1'b1 || dif.tx_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL basic_first got valid=%b data=%h want 1/00", dif.tx_valid, dif.tx_data);
    end
    wait_done(100, ok);
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (!ok || done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL basic_done got %0d pulses want 1", done_cnt);
    end
    tests_run++;
    if (done_cyc !== e1 + 18 + CK || busy_at_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done_time got cyc=%0d busy=%b want cyc=%0d busy=0", done_cyc - e1, busy_at_done, 18 + CK);
    end
    tests_run++;
    if (rd_q.size() != 3 || rd_q[0] !== 8'd250 || rd_q[1] !== 8'd251 || rd_q[2] !== 8'd252) begin
      tests_failed++;
      $display("FAIL basic_reads got %p want 250 251 252", rd_q);
    end
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL basic_len got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL basic_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int e1;
    logic pat [16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                       1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic prev_stall;
    logic [7:0] prev_data;
    int d0;
    clear_logs();
    push_word(32'd12);
    push_word(32'd5);
    push_word(32'hFFFF_FFF8);
    if (CK != 0) exp_q.push_back(8'h06);
    dif.tx_ready = 1'b0;
    pulse_start(8'd250, 9'd3, e1);
    d0 = done_cnt;
    prev_stall = 1'b0;
    prev_data = 8'h00;
    for (int i = 0; i < 400 && done_cnt == d0; i++) begin
      @(posedge clk);
      #1;
      dif.tx_ready = pat[i % 16];
      @(negedge clk);
      if (prev_stall) begin
        tests_run++;
        if (dif.tx_valid !== 1'b1 || dif.tx_data !== prev_data) begin
          tests_failed++;
          $display("FAIL bp_stable got valid=%b data=%h want 1/%h", dif.tx_valid, dif.tx_data, prev_data);
        end
      end
      prev_stall = dif.tx_valid && !dif.tx_ready;
      prev_data = dif.tx_data;
    end
    @(posedge clk);
    #1;
    dif.tx_ready = 1'b0;
    tests_run++;
    if (done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL bp_done got %0d pulses want 1", done_cnt);
    end
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL bp_len got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL bp_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int e1;
    bit ok;
    clear_logs();
    push_word(32'h1122_3344);
    push_word(32'h2008_0000);
    if (CK != 0) exp_q.push_back(8'hD2);
    dif.tx_ready = 1'b1;
    pulse_start(8'd255, 9'd2, e1);
    wait_done(100, ok);
    tests_run++;
    if (!ok || done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL wrap_done got %0d pulses want 1", done_cnt);
    end
    tests_run++;
    if (rd_q.size() != 2 || rd_q[0] !== 8'd255 || rd_q[1] !== 8'd0) begin
      tests_failed++;
      $display("FAIL wrap_reads got %p want 255 0", rd_q);
    end
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL wrap_len got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL wrap_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_zero_and_ignore();
    int e1;
    int dummy;
    bit ok;
    clear_logs();
    dif.tx_ready = 1'b1;
    pulse_start(8'd7, 9'd0, e1);
    wait_done(10, ok);
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (!ok || done_cyc !== e1 || done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL zero_done got cyc=%0d cnt=%0d want cyc=0 cnt=1", done_cyc - e1, done_cnt);
    end
    tests_run++;
    if (valid_seen !== 1'b0 || rd_q.size() != 0) begin
      tests_failed++;
      $display("FAIL zero_quiet got valid_seen=%b reads=%0d want 0/0", valid_seen, rd_q.size());
    end
    clear_logs();
    push_word(32'd12);
    if (CK != 0) exp_q.push_back(8'h0C);
    pulse_start(8'd250, 9'd1, e1);
    repeat (3) @(posedge clk);
    #1;
    pulse_start(8'd0, 9'd5, dummy);
    wait_done(50, ok);
    repeat (20) @(posedge clk);
    #1;
    tests_run++;
    if (!ok || done_cnt !== 1 || dif.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignore_done got cnt=%0d busy=%b want 1/0", done_cnt, dif.busy);
    end
    tests_run++;
    if (rd_q.size() != 1 || rd_q[0] !== 8'd250) begin
      tests_failed++;
      $display("FAIL ignore_reads got %p want 250", rd_q);
    end
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL ignore_len got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL ignore_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int e1;
    bit ok;
    clear_logs();
    dif.tx_ready = 1'b1;
    pulse_start(8'd250, 9'd3, e1);
    repeat (10) @(posedge clk);
    #3;
    tests_run++;
    if (dif.tx_valid !== 1'b1 || dif.tx_data !== 8'h00 || dbg_state !== 3'd3) begin
      tests_failed++;
      $display("FAIL rmid_pre got valid=%b data=%h state=%0d want 1/00/3", dif.tx_valid, dif.tx_data, dbg_state);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if ({dif.busy, dif.done, dif.mem_rd_en, dif.tx_valid} !== 4'b0000 ||
        dif.mem_addr !== 8'h00 || dif.tx_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL rmid_outputs got ctrl=%b addr=%h data=%h want 0000/00/00",
               {dif.busy, dif.done, dif.mem_rd_en, dif.tx_valid}, dif.mem_addr, dif.tx_data);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
    push_word(32'd12);
    if (CK != 0) exp_q.push_back(8'h0C);
    pulse_start(8'd250, 9'd1, e1);
    wait_done(50, ok);
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (!ok || done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL rmid_done got %0d pulses want 1", done_cnt);
    end
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL rmid_len got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL rmid_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 | i;
    mem[250] = 32'd12;
    mem[251] = 32'd5;
    mem[252] = 32'hFFFF_FFF8;
    mem[255] = 32'h1122_3344;
    mem[0]   = 32'h2008_0000;
    dif.start = 1'b0;
    dif.base_addr = 8'h00;
    dif.word_count = 9'd0;
    dif.tx_ready = 1'b0;
    #2;
    reset = 1'b0;
    test_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_and_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/mem_dump_reader.md
# mem_dump_reader

Read-back unit for the multicycle processor's unified word memory: on a start pulse it reads a contiguous range of 32-bit words through a synchronous read port and serializes them MSB-first as bytes on a valid/ready byte stream. The program loader writes memory; this block is its counterpart, exporting results such as stored stack words to a host or bench without hierarchical probing. It sits beside `processor`, sharing the data memory's read port while the core is halted.

## Interface
- `ADDR_W`, 8: word-address width (memory depth 2^ADDR_W words).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first word address; latched on accepted `start`.
- `word_count`  in  ADDR_W+1  number of words to dump (0..2^ADDR_W); latched on accepted `start`.
- `busy`  out  1  high from the cycle after `start` acceptance until `done`.
- `done`  out  1  one-cycle pulse when dump completes.
- `mem_rd_en`  out  1  read strobe to memory.
- `mem_addr`  out  ADDR_W  word address to memory.
- `mem_rdata`  in  32  read data, valid one cycle after `mem_rd_en`.
- `tx_data`  out  8  stream byte.
- `tx_valid`  out  1  byte valid.
- `tx_ready`  in  1  sink accepts byte when `tx_valid && tx_ready` at a rising edge.

## Operation
- States: IDLE, READ, WAIT, SEND, CKSUM (only with the macro enabled), FINISH.
- IDLE: `start` high -> latch `base_addr`, `word_count`, clear the word counter and checksum; go to READ, or to FINISH if `word_count`==0.
- READ: `mem_rd_en`=1, `mem_addr`=base+index (mod 2^ADDR_W, wraps from 2^ADDR_W-1 to 0); -> WAIT.
- WAIT: capture `mem_rdata` into the 32-bit shift register; -> SEND.
- SEND: `tx_data` = shift[31:24]. On handshake, shift left by 8 and increment the byte counter (2 bits). After the 4th byte, increment the word index. If index==count -> CKSUM (macro enabled) or FINISH; else -> READ.
- FINISH: `done`=1 for one cycle; -> IDLE.
- `start` is ignored while not in IDLE. `base_addr`/`word_count` changes after acceptance have no effect.
- `mem_addr` holds its last value outside READ. `mem_rd_en` is high only in READ.
- Reset (asynchronous, any state) -> IDLE. All outputs go to 0 immediately: `busy`, `done`, `mem_rd_en`, `mem_addr`, `tx_data`, `tx_valid`. Any in-flight dump is abandoned and no partial byte is completed.

## Timing
- `start` accepted at edge E0 -> READ in cycle E0+1 -> WAIT -> first `tx_valid` in cycle E0+3.
- `tx_valid` stays high and `tx_data` stays stable until handshake; no combinational path from `tx_ready` to `tx_valid`.
- With `tx_ready` held high: 4 byte cycles per word plus a 2-cycle READ/WAIT gap, i.e. 6 cycles/word.
- `done` asserts the cycle after the last byte (or checksum byte) handshake. `busy` deasserts in the same cycle as `done`.
- `word_count`==0: `done` in cycle E0+1, no memory reads, no bytes.

## Configuration
- `DUMP_CHECKSUM_EN` defined: after the last data byte, CKSUM sends one extra byte equal to the 8-bit modulo-256 sum of all data bytes of this dump. It uses the same handshake and precedes FINISH.
- Undefined: no CKSUM state; the stream ends with the last data byte.

## Test plan
- Preload mem[250]=12, mem[251]=5, mem[252]=0xFFFFFFF8; start base=250, count=3, `tx_ready`=1 -> bytes 00 00 00 0C 00 00 00 05 FF FF FF F8. With checksum enabled, a trailing 0x06 follows. One `done` pulse; 18 cycles of data after the first `tx_valid` gap pattern.
- Backpressure: same dump with `tx_ready` toggled 1-0-0-1 pseudo-randomly -> identical byte sequence, `tx_data` stable while stalled, no byte duplicated or dropped.
- Wrap: base=255, count=2, mem[255]=0x11223344, mem[0]=0x20080000 -> reads addr 255 then 0; bytes 11 22 33 44 20 08 00 00.
- count=0 -> `done` one cycle after start, `tx_valid` and `mem_rd_en` never high; a `start` pulse during an active dump is ignored, and only one `done` is produced.
- Reset asserted low mid-SEND (byte 2 of word 1) -> `tx_valid`, `busy`, `mem_rd_en` drop to 0 immediately. After release, a new start base=250, count=1 -> 00 00 00 0C only.
